// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
//   Drives the Avalon-MM management port of the ram-clock PLL reconfiguration
//   block. A start pulse latches one frequency entry (M, K, C0). The sequencer
//   then writes the fixed eight-register table, pulses the PLL reset and waits
//   for lock, or gives up after a timeout.
// Ports
//   clk, reset                 management clock, async active-high reset
//   start, m_val/k_val/c_val   1-cycle request and the frequency words it latches
//   locked                     PLL lock (asynchronous, synchronised here)
//   mgmt_waitrequest           Avalon waitrequest from the reconfig block
//   mgmt_write/address/wdata   Avalon write master outputs
//   pll_reset                  PLL reset pulse, RST_CYCLES wide
//   busy                       high while a sequence is in progress
//   done                       1-cycle pulse when lock is achieved
//   lock_err                   sticky lock-timeout flag, cleared by start
module pll_reconfig_seq #(
  parameter int unsigned GAP_CYCLES   = 7,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_TIMEOUT = 5000000,
  parameter logic [31:0] N_VALUE      = 32'h10000,
  parameter logic [31:0] CP_VALUE     = 32'd1,
  parameter logic [31:0] BW_VALUE     = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] m_val,
  input  logic [31:0] k_val,
  input  logic [31:0] c_val,
  input  logic        locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        pll_reset,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned RST_W = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
  // The first GAP cycle is the mandatory write-low cycle, so a GAP of N
  // occupies N cycles (minimum one) and writes land N+1 cycles apart.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
  localparam logic [31:0]      TO_LAST  = 32'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_GAP,
    S_RST,
    S_LOCKWAIT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic             r_restart, w_restart_nxt;
  logic             w_load, w_done_nxt, w_err_set;
  logic [31:0]      r_m, r_k, r_c;
  logic [5:0]       r_addr;
  logic [31:0]      r_wdata;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [RST_W-1:0] r_rst_cnt;
  logic [31:0]      r_to_cnt;
  logic             r_lock_s1, r_lock_s2;
  logic             r_done, r_lock_err;

  function automatic logic [5:0] tbl_addr(input logic [2:0] i);
    case (i)
      3'd0:    return 6'd0;
      3'd1:    return 6'd4;
      3'd2:    return 6'd7;
      3'd3:    return 6'd3;
      3'd4:    return 6'd5;
      3'd5:    return 6'd9;
      3'd6:    return 6'd8;
      default: return 6'd2;
    endcase
  endfunction

  function automatic logic [31:0] tbl_data(input logic [2:0] i, input logic [31:0] m,
                                           input logic [31:0] k, input logic [31:0] c);
    case (i)
      3'd1:    return m;
      3'd2:    return k;
      3'd3:    return N_VALUE;
      3'd4:    return c;
      3'd5:    return CP_VALUE;
      3'd6:    return BW_VALUE;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_load        = 1'b0;
    w_restart_nxt = r_restart;
    w_done_nxt    = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WRITE;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      S_WRITE: begin
        // A restart requested during a stalled write is remembered and only
        // taken once the write has been accepted.
        if (!mgmt_waitrequest) begin
          if (start || r_restart) begin
            w_state_nxt   = S_WRITE;
            w_idx_nxt     = '0;
            w_load        = 1'b1;
            w_restart_nxt = 1'b0;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else if (start) begin
          w_restart_nxt = 1'b1;
        end
      end
      S_GAP: begin
        if (start) begin
          w_state_nxt = S_WRITE;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end else if (r_gap_cnt == GAP_LAST) begin
          if (r_idx == 3'd7) begin
            w_state_nxt = S_RST;
          end else begin
            w_state_nxt = S_WRITE;
            w_idx_nxt   = r_idx + 3'd1;
            w_load      = 1'b1;
          end
        end
      end
      S_RST: begin
        if (start) begin
          w_state_nxt = S_WRITE;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end else if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = S_LOCKWAIT;
        end
      end
      S_LOCKWAIT: begin
        // Priority: restart, then lock, then timeout.
        if (start) begin
          w_state_nxt = S_WRITE;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end else if (r_lock_s2) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_to_cnt >= TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_restart  <= 1'b0;
      r_m        <= '0;
      r_k        <= '0;
      r_c        <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_gap_cnt  <= '0;
      r_rst_cnt  <= '0;
      r_to_cnt   <= '0;
      r_lock_s1  <= 1'b0;
      r_lock_s2  <= 1'b0;
      r_done     <= 1'b0;
      r_lock_err <= 1'b0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_restart <= w_restart_nxt;
      r_lock_s1 <= locked;
      r_lock_s2 <= r_lock_s1;
      r_done    <= w_done_nxt;
      if (start) begin
        r_m <= m_val;
        r_k <= k_val;
        r_c <= c_val;
      end
      if (start)          r_lock_err <= 1'b0;
      else if (w_err_set) r_lock_err <= 1'b1;
      // Address/data are captured on entry to WRITE so a restart that
      // re-latches the words cannot disturb a stalled write.
      if (w_load) begin
        r_addr  <= tbl_addr(w_idx_nxt);
        r_wdata <= tbl_data(w_idx_nxt, r_m, r_k, r_c);
      end
      r_gap_cnt <= (r_state == S_GAP && w_state_nxt == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
      r_rst_cnt <= (r_state == S_RST && w_state_nxt == S_RST) ? r_rst_cnt + RST_W'(1) : '0;
      if (r_state == S_LOCKWAIT && w_state_nxt == S_LOCKWAIT) begin
        if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + 32'd1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign mgmt_write     = (r_state == S_WRITE);
  assign mgmt_address   = r_addr;
  assign mgmt_writedata = r_wdata;
  assign pll_reset      = (r_state == S_RST);
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign lock_err       = r_lock_err;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
module tb_pll_reconfig_seq;

  localparam int GAP = 7;
  localparam int RSTW = 8;
  localparam int TO = 120;

  localparam int EV_WR   = 0;
  localparam int EV_RST  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  localparam int C_PR_HI = 0;
  localparam int C_PR_LO = 1;
  localparam int C_WR_AT = 2;
  localparam int C_IDLE  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] m_val = '0, k_val = '0, c_val = '0;
  logic        locked = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        pll_reset, busy, done, lock_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          kind;
    logic [5:0]  a;
    logic [31:0] d;
    int          p;
  } ev_t;
  ev_t q[$];

  pll_reconfig_seq #(
    .GAP_CYCLES(GAP),
    .RST_CYCLES(RSTW),
    .LOCK_TIMEOUT(TO),
    .N_VALUE(32'h10000),
    .CP_VALUE(32'd1),
    .BW_VALUE(32'd7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .m_val(m_val),
    .k_val(k_val),
    .c_val(c_val),
    .locked(locked),
    .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_write(mgmt_write),
    .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata),
    .pll_reset(pll_reset),
    .busy(busy),
    .done(done),
    .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [5:0] a, input logic [31:0] d, input int p);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.p = p;
    q.push_back(e);
  endtask

  // Expected write table for one run; gap is checked except for idx 0 and 'skip'.
  task automatic push_run(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                          input int nwr, input bit with_rst, input int skip);
    logic [5:0]  ad [8];
    logic [31:0] dt [8];
    ad = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
    dt = '{32'd0, m, k, 32'h10000, c, 32'd1, 32'd7, 32'd0};
    for (int i = 0; i < nwr; i++)
      push_ev(EV_WR, ad[i], dt[i], (i == 0 || i == skip) ? 0 : GAP + 1);
    if (with_rst) push_ev(EV_RST, '0, '0, RSTW);
  endtask

  task automatic expect_ev(input int kind, input logic [5:0] a, input logic [31:0] d, input int p);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=0x%0h p=%0d, expected none at %0t",
               kind, a, d, p, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == EV_WR && (e.a !== a || e.d !== d)) ||
          (e.p != 0 && e.p != p)) begin
        failures++;
        $display("FAIL event: got kind=%0d addr=%0d data=0x%0h p=%0d, expected kind=%0d addr=%0d data=0x%0h p=%0d at %0t",
                 kind, a, d, p, e.kind, e.a, e.d, e.p, $time);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int          ncyc = 0;
  int          last_acc = 0;
  int          pr_w = 0;
  int          pr_fall = 0;
  logic        prev_stall = 1'b0;
  logic [5:0]  prev_a = '0;
  logic [31:0] prev_d = '0;
  logic        prev_done = 1'b0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (prev_stall) begin
      checks++;
      if (mgmt_write !== 1'b1 || mgmt_address !== prev_a || mgmt_writedata !== prev_d) begin
        failures++;
        $display("FAIL write_hold: got wr=%0b addr=%0d data=0x%0h, expected wr=1 addr=%0d data=0x%0h at %0t",
                 mgmt_write, mgmt_address, mgmt_writedata, prev_a, prev_d, $time);
      end
    end
    prev_stall = mgmt_write && mgmt_waitrequest;
    prev_a = mgmt_address;
    prev_d = mgmt_writedata;
    if (mgmt_write === 1'b1 && mgmt_waitrequest === 1'b0) begin
      expect_ev(EV_WR, mgmt_address, mgmt_writedata, ncyc - last_acc);
      last_acc = ncyc;
    end
    if (pll_reset === 1'b1) begin
      pr_w++;
    end else if (pr_w > 0) begin
      expect_ev(EV_RST, '0, '0, pr_w);
      pr_w = 0;
      pr_fall = ncyc;
    end
    if (done === 1'b1) begin
      expect_ev(EV_DONE, '0, '0, 1);
      chk("done_busy_low", {31'd0, busy}, 32'd0);
      chk("done_no_err", {31'd0, lock_err}, 32'd0);
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
    end
    if (lock_err === 1'b1 && prev_err === 1'b0) begin
      expect_ev(EV_ERR, '0, '0, ncyc - pr_fall);
      chk("err_no_done", {31'd0, done}, 32'd0);
      chk("err_busy_low", {31'd0, busy}, 32'd0);
    end
    prev_done = done;
    prev_err = lock_err;
  end

  function automatic bit cond(input int sel, input logic [5:0] a);
    case (sel)
      C_PR_HI: return pll_reset === 1'b1;
      C_PR_LO: return pll_reset === 1'b0;
      C_WR_AT: return mgmt_write === 1'b1 && mgmt_address === a;
      C_IDLE:  return busy === 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_neg(input int sel, input logic [5:0] a, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!cond(sel, a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cond(sel, a)) begin
      checks++;
      failures++;
      $display("FAIL wait_%s: got timeout after %0d cycles, expected condition %0d", nm, n, sel);
    end
  endtask

  task automatic pulse_start(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c);
    @(posedge clk);
    #1;
    start = 1'b1; m_val = m; k_val = k; c_val = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic lock_after(input int n);
    wait_neg(C_PR_HI, '0, "prst_hi");
    wait_neg(C_PR_LO, '0, "prst_lo");
    repeat (n) @(posedge clk);
    #1 locked = 1'b1;
    wait_neg(C_IDLE, '0, "idle_lock");
    @(posedge clk);
    #1 locked = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_write", {31'd0, mgmt_write}, 32'd0);
    chk("rst_addr", {26'd0, mgmt_address}, 32'd0);
    chk("rst_data", mgmt_writedata, 32'd0);
    chk("rst_pllrst", {31'd0, pll_reset}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, lock_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // Full sequence, 8 writes 8 cycles apart, lock 100 cycles after reset falls
    push_run(32'h00505, 32'h66666666, 32'h00505, 8, 1'b1, -1);
    push_ev(EV_DONE, '0, '0, 0);
    pulse_start(32'h00505, 32'h66666666, 32'h00505);
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    lock_after(100);

    // Stall on idx 2 for 5 cycles
    push_run(32'h00a0a, 32'h12345678, 32'h00303, 8, 1'b1, 2);
    push_ev(EV_DONE, '0, '0, 0);
    pulse_start(32'h00a0a, 32'h12345678, 32'h00303);
    wait_neg(C_WR_AT, 6'd4, "wr_idx1");
    @(posedge clk);
    #1 mgmt_waitrequest = 1'b1;
    wait_neg(C_WR_AT, 6'd7, "wr_idx2");
    for (int i = 0; i < 6; i++) begin
      chk("stall_write", {31'd0, mgmt_write}, 32'd1);
      chk("stall_addr", {26'd0, mgmt_address}, 32'd7);
      chk("stall_data", mgmt_writedata, 32'h12345678);
      if (i == 4) begin
        @(posedge clk);
        #1 mgmt_waitrequest = 1'b0;
      end
      if (i < 5) @(negedge clk);
    end
    lock_after(10);

    // Lock timeout
    push_run(32'h00606, 32'h0, 32'h00202, 8, 1'b1, -1);
    push_ev(EV_ERR, '0, '0, TO);
    pulse_start(32'h00606, 32'h0, 32'h00202);
    wait_neg(C_PR_HI, '0, "prst_hi_to");
    wait_neg(C_PR_LO, '0, "prst_lo_to");
    wait_neg(C_IDLE, '0, "idle_to");
    chk("timeout_err", {31'd0, lock_err}, 32'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", {31'd0, lock_err}, 32'd1);

    // Restart during a stalled idx 4 write; start also clears lock_err
    push_run(32'h00505, 32'h11111111, 32'h00707, 5, 1'b0, 4);
    push_run(32'h00404, 32'h22222222, 32'h00808, 8, 1'b1, -1);
    push_ev(EV_DONE, '0, '0, 0);
    pulse_start(32'h00505, 32'h11111111, 32'h00707);
    @(negedge clk);
    chk("start_clears_err", {31'd0, lock_err}, 32'd0);
    chk("busy_restart_run", {31'd0, busy}, 32'd1);
    wait_neg(C_WR_AT, 6'd3, "wr_idx3");
    @(posedge clk);
    #1 mgmt_waitrequest = 1'b1;
    wait_neg(C_WR_AT, 6'd5, "wr_idx4");
    pulse_start(32'h00404, 32'h22222222, 32'h00808);
    repeat (2) @(posedge clk);
    #1 mgmt_waitrequest = 1'b0;
    lock_after(20);

    // Async reset while pll_reset is high, then a clean full run
    push_run(32'h00303, 32'h33333333, 32'h00303, 8, 1'b0, -1);
    push_ev(EV_RST, '0, '0, 0);
    pulse_start(32'h00303, 32'h33333333, 32'h00303);
    wait_neg(C_PR_HI, '0, "prst_hi_rst");
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_pllrst", {31'd0, pll_reset}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_write", {31'd0, mgmt_write}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    push_run(32'h00909, 32'h44444444, 32'h00101, 8, 1'b1, -1);
    push_ev(EV_DONE, '0, '0, 0);
    pulse_start(32'h00909, 32'h44444444, 32'h00101);
    lock_after(10);

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
